// File: rtl/miner_job_scheduler_if.sv
// Bundle between the job scheduler, the host register bank and the miner core array.
// master = scheduler side, slave = host/cores/result-consumer side.
interface miner_job_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int CORE_ID_W = 3
);
  logic                     job_valid;
  logic                     job_ready;
  logic [31:0]              job_nonce_base;
  logic                     job_done;
  logic                     job_found_any;
  logic [NUM_CORES-1:0]     core_start;
  logic [32*NUM_CORES-1:0]  core_nonce_in;
  logic [NUM_CORES-1:0]     core_done;
  logic [NUM_CORES-1:0]     core_found;
  logic [32*NUM_CORES-1:0]  core_nonce_out;
  logic                     res_valid;
  logic                     res_ready;
  logic [CORE_ID_W-1:0]     res_core_id;
  logic [31:0]              res_nonce;
  logic [31:0]              stat_cycles;
  logic [7:0]               stat_found;

  modport master (
    input  job_valid, job_nonce_base, core_done, core_found, core_nonce_out, res_ready,
    output job_ready, job_done, job_found_any, core_start, core_nonce_in,
           res_valid, res_core_id, res_nonce, stat_cycles, stat_found
  );

  modport slave (
    output job_valid, job_nonce_base, core_done, core_found, core_nonce_out, res_ready,
    input  job_ready, job_done, job_found_any, core_start, core_nonce_in,
           res_valid, res_core_id, res_nonce, stat_cycles, stat_found
  );
endinterface

// File: rtl/miner_job_scheduler.sv
// Splits one mining job into per-core nonce slices, tracks cores to completion and returns found nonces round-robin.
// Results hold under res_ready=0; job counters exist only when MINER_SCHED_STATS_EN is defined.
module miner_job_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int CORE_ID_W = 3
) (
  input logic                   clk,
  input logic                   arst,
  miner_job_scheduler_if.master bus
);
  localparam int LOG2_CORES  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 0;
  localparam int SLICE_SHIFT = 32 - LOG2_CORES;

  typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;

  state_t                  state;
  state_t                  state_next;

  logic [NUM_CORES-1:0]    busy;
  logic [NUM_CORES-1:0]    pend;
  logic [31:0]             pend_nonce [NUM_CORES];
  logic [32*NUM_CORES-1:0] nonce_in;
  logic [CORE_ID_W-1:0]    rr;
  logic                    found_any;

  logic                    res_valid;
  logic [CORE_ID_W-1:0]    res_core_id;
  logic [31:0]             res_nonce;

  logic                    accept;
  logic                    job_ready;
  logic                    job_done;
  logic                    start_all;
  logic                    arb_en;
  logic                    res_fire;
  logic [NUM_CORES-1:0]    finish;
  logic [NUM_CORES-1:0]    found_set;

  logic                    grant_vld;
  logic [CORE_ID_W-1:0]    grant_idx;
  logic [NUM_CORES-1:0]    grant_mask;
  logic [31:0]             grant_nonce;

  function automatic logic [31:0] slice_off(input int idx);
    logic [63:0] wide;
    wide = 64'(idx) << SLICE_SHIFT;
    return wide[31:0];
  endfunction

  assign accept    = (state == IDLE) && bus.job_valid;
  assign arb_en    = (state == RUN) || (state == DRAIN);
  assign res_fire  = res_valid && bus.res_ready;
  // busy is set on the start edge, so the pre-start core_done=1 never reaches this mask.
  assign finish    = (state == RUN) ? (busy & bus.core_done) : '0;
  assign found_set = finish & bus.core_found;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    job_ready  = 1'b0;
    job_done   = 1'b0;
    start_all  = 1'b0;
    case (state)
      IDLE: begin
        job_ready = 1'b1;
        if (bus.job_valid) state_next = START;
      end
      START: begin
        start_all  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (busy == '0) state_next = DRAIN;
      end
      DRAIN: begin
        if ((pend == '0) && !res_valid) begin
          job_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // First pending core at or after rr, wrapping around to the lower indices.
  always_comb begin
    grant_vld   = 1'b0;
    grant_idx   = '0;
    grant_mask  = '0;
    grant_nonce = '0;
    if (arb_en && !res_valid) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!grant_vld && pend[i] && (i >= int'(rr))) begin
          grant_vld = 1'b1;
          grant_idx = CORE_ID_W'(i);
        end
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!grant_vld && pend[i] && (i < int'(rr))) begin
          grant_vld = 1'b1;
          grant_idx = CORE_ID_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_vld && (int'(grant_idx) == i)) begin
        grant_mask[i] = 1'b1;
        grant_nonce   = pend_nonce[i];
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      busy        <= '0;
      pend        <= '0;
      nonce_in    <= '0;
      rr          <= '0;
      found_any   <= 1'b0;
      res_valid   <= 1'b0;
      res_core_id <= '0;
      res_nonce   <= '0;
      for (int i = 0; i < NUM_CORES; i++) pend_nonce[i] <= '0;
    end else begin
      if (accept) begin
        busy      <= '0;
        pend      <= '0;
        found_any <= 1'b0;
        for (int i = 0; i < NUM_CORES; i++)
          nonce_in[32*i +: 32] <= bus.job_nonce_base + slice_off(i);
      end else begin
        busy <= (state == START) ? '1 : (busy & ~finish);
        pend <= (pend | found_set) & ~grant_mask;
        if (found_set != '0) found_any <= 1'b1;
      end

      for (int i = 0; i < NUM_CORES; i++)
        if (found_set[i]) pend_nonce[i] <= bus.core_nonce_out[32*i +: 32];

      if (grant_vld) begin
        res_valid   <= 1'b1;
        res_core_id <= grant_idx;
        res_nonce   <= grant_nonce;
        rr          <= CORE_ID_W'((int'(grant_idx) + 1) % NUM_CORES);
      end else if (res_fire) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign bus.job_ready     = job_ready;
  assign bus.job_done      = job_done;
  assign bus.job_found_any = found_any;
  assign bus.core_start    = {NUM_CORES{start_all}};
  assign bus.core_nonce_in = nonce_in;
  assign bus.res_valid     = res_valid;
  assign bus.res_core_id   = res_core_id;
  assign bus.res_nonce     = res_nonce;

`ifdef MINER_SCHED_STATS_EN
  logic [31:0] stat_cycles;
  logic [7:0]  stat_found;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stat_cycles <= '0;
      stat_found  <= '0;
    end else if (accept) begin
      stat_cycles <= '0;
      stat_found  <= '0;
    end else begin
      if ((state != IDLE) && (stat_cycles != '1)) stat_cycles <= stat_cycles + 32'd1;
      if (res_fire && (stat_found != '1))         stat_found  <= stat_found + 8'd1;
    end
  end

  assign bus.stat_cycles = stat_cycles;
  assign bus.stat_found  = stat_found;
`else
  assign bus.stat_cycles = '0;
  assign bus.stat_found  = '0;
`endif
endmodule

// File: tb/tb_miner_job_scheduler.sv
// Directed bench for miner_job_scheduler with NUM_CORES=4; cores are modelled by hand-driven done/found vectors.
module tb_miner_job_scheduler;
`ifdef MINER_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic arst;
  int   n_vec;
  int   n_err;

  miner_job_scheduler_if #(.NUM_CORES(4), .CORE_ID_W(3)) bus ();

  miner_job_scheduler #(.NUM_CORES(4), .CORE_ID_W(3)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    arst  = 1'b1;
    bus.job_valid      = 1'b0;
    bus.job_nonce_base = '0;
    bus.core_done      = 4'hF;
    bus.core_found     = '0;
    bus.core_nonce_out = '0;
    bus.res_ready      = 1'b0;
    tick();
    tick();
    arst = 1'b0;
    tick();

    check("rst_job_ready",   bus.job_ready, 1);
    check("rst_job_done",    bus.job_done, 0);
    check("rst_found_any",   bus.job_found_any, 0);
    check("rst_core_start",  bus.core_start, 0);
    check("rst_nonce_in",    bus.core_nonce_in, 0);
    check("rst_res_valid",   bus.res_valid, 0);
    check("rst_res_core_id", bus.res_core_id, 0);
    check("rst_res_nonce",   bus.res_nonce, 0);
    check("rst_stat_cycles", bus.stat_cycles, 0);
    check("rst_stat_found",  bus.stat_found, 0);

    // Job 1: base 0x10, cores 1 and 3 find together
    bus.job_valid      = 1'b1;
    bus.job_nonce_base = 32'h0000_0010;
    bus.res_ready      = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    check("j1_core_start", bus.core_start, 4'hF);
    check("j1_busy_ready", bus.job_ready, 0);
    check("j1_nonce_in",   bus.core_nonce_in, 128'hC000_0010_8000_0010_4000_0010_0000_0010);
    tick();
    check("j1_start_1cyc", bus.core_start, 0);
    bus.core_done = 4'h0;
    repeat (3) tick();
    check("j1_run_no_res", bus.res_valid, 0);
    bus.core_done = 4'b0101;
    tick();
    bus.core_done      = 4'hF;
    bus.core_found     = 4'b1010;
    bus.core_nonce_out = {32'h0000_0033, 32'h0, 32'h0000_0011, 32'h0};
    tick();
    check("j1_pend_no_res_yet", bus.res_valid, 0);
    check("j1_found_any",       bus.job_found_any, 1);
    tick();
    check("j1_r0_valid", bus.res_valid, 1);
    check("j1_r0_id",    bus.res_core_id, 1);
    check("j1_r0_nonce", bus.res_nonce, 32'h11);
    tick();
    check("j1_r0_gap_valid", bus.res_valid, 0);
    check("j1_r0_gap_done",  bus.job_done, 0);
    tick();
    check("j1_r1_valid", bus.res_valid, 1);
    check("j1_r1_id",    bus.res_core_id, 3);
    check("j1_r1_nonce", bus.res_nonce, 32'h33);
    tick();
    check("j1_r1_gap_valid", bus.res_valid, 0);
    check("j1_job_done",     bus.job_done, 1);
    check("j1_done_not_rdy", bus.job_ready, 0);
    tick();
    check("j1_done_pulse",  bus.job_done, 0);
    check("j1_ready_again", bus.job_ready, 1);
    check("j1_found_hold",  bus.job_found_any, 1);
    check("j1_stat_found",  bus.stat_found, STATS ? 2 : 0);
    check("j1_stat_cycles", bus.stat_cycles, STATS ? 11 : 0);

    // Job 2: wrapping base, one result held under res_ready=0
    bus.core_found     = '0;
    bus.core_nonce_out = '0;
    bus.res_ready      = 1'b0;
    bus.job_valid      = 1'b1;
    bus.job_nonce_base = 32'hF000_0000;
    tick();
    bus.job_valid = 1'b0;
    check("j2_nonce_wrap", bus.core_nonce_in, 128'hB000_0000_7000_0000_3000_0000_F000_0000);
    tick();
    bus.core_done      = 4'h0;
    bus.job_valid      = 1'b1;
    bus.job_nonce_base = 32'h1234_5678;
    tick();
    bus.job_valid = 1'b0;
    check("j2_ignore_ready", bus.job_ready, 0);
    check("j2_ignore_nonce", bus.core_nonce_in, 128'hB000_0000_7000_0000_3000_0000_F000_0000);
    check("j2_ignore_start", bus.core_start, 0);
    bus.core_done      = 4'hF;
    bus.core_found     = 4'b0100;
    bus.core_nonce_out = {32'h0, 32'h2222_2222, 64'h0};
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      check("j2_hold_valid", bus.res_valid, 1);
      check("j2_hold_id",    bus.res_core_id, 2);
      check("j2_hold_nonce", bus.res_nonce, 32'h2222_2222);
      check("j2_hold_done",  bus.job_done, 0);
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    check("j2_hs_valid", bus.res_valid, 0);
    check("j2_job_done", bus.job_done, 1);
    tick();
    check("j2_ready_again", bus.job_ready, 1);
    check("j2_stat_found",  bus.stat_found, STATS ? 1 : 0);
    check("j2_stat_cycles", bus.stat_cycles, STATS ? 16 : 0);

    // Job 3: no core finds anything
    bus.core_found     = '0;
    bus.core_nonce_out = '0;
    bus.job_valid      = 1'b1;
    bus.job_nonce_base = 32'h0;
    tick();
    bus.job_valid = 1'b0;
    check("j3_found_clr", bus.job_found_any, 0);
    check("j3_stat_clr",  bus.stat_found, 0);
    tick();
    bus.core_done = 4'h0;
    tick();
    bus.core_done = 4'hF;
    tick();
    check("j3_not_done_yet", bus.job_done, 0);
    check("j3_no_res_run",   bus.res_valid, 0);
    tick();
    check("j3_job_done",  bus.job_done, 1);
    check("j3_no_res",    bus.res_valid, 0);
    check("j3_found_any", bus.job_found_any, 0);
    tick();
    check("j3_ready_again", bus.job_ready, 1);
    check("j3_stat_cycles", bus.stat_cycles, STATS ? 5 : 0);

    // Job 4: async reset while core 1's result is outstanding
    bus.job_valid      = 1'b1;
    bus.job_nonce_base = 32'h0000_0100;
    bus.res_ready      = 1'b0;
    tick();
    bus.job_valid = 1'b0;
    tick();
    bus.core_done = 4'h0;
    tick();
    bus.core_done      = 4'b0010;
    bus.core_found     = 4'b0010;
    bus.core_nonce_out = {64'h0, 32'h0000_00AB, 32'h0};
    tick();
    tick();
    check("j4_pre_rst_valid", bus.res_valid, 1);
    check("j4_pre_rst_id",    bus.res_core_id, 1);
    #2;
    arst               = 1'b1;
    bus.core_done      = 4'hF;
    bus.core_found     = '0;
    bus.core_nonce_out = '0;
    #1;
    check("j4_rst_job_ready", bus.job_ready, 1);
    check("j4_rst_res_valid", bus.res_valid, 0);
    check("j4_rst_res_id",    bus.res_core_id, 0);
    check("j4_rst_res_nonce", bus.res_nonce, 0);
    check("j4_rst_nonce_in",  bus.core_nonce_in, 0);
    check("j4_rst_found_any", bus.job_found_any, 0);
    check("j4_rst_start",     bus.core_start, 0);
    check("j4_rst_done",      bus.job_done, 0);
    tick();
    arst = 1'b0;
    tick();
    bus.job_valid      = 1'b1;
    bus.job_nonce_base = 32'h0000_0010;
    tick();
    bus.job_valid = 1'b0;
    check("j5_core_start", bus.core_start, 4'hF);
    check("j5_nonce_in",   bus.core_nonce_in, 128'hC000_0010_8000_0010_4000_0010_0000_0010);
    tick();
    bus.core_done = 4'h0;
    tick();
    bus.core_done = 4'hF;
    tick();
    tick();
    check("j5_job_done", bus.job_done, 1);
    check("j5_no_stale", bus.res_valid, 0);
    tick();
    check("j5_ready_again", bus.job_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
